// File: rtl/unaligned_mem_if.sv
// Request/response bundle for the unaligned four-bank byte memory port.
// The optional wstrb lane exists only when UNALIGNED_MEM_BYTE_MASK_EN is defined.
interface unaligned_mem_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              busy;
`ifdef UNALIGNED_MEM_BYTE_MASK_EN
    logic [3:0]        wstrb;

    modport master (output req, wen, addr, wdata, wstrb, input rdata, ack, busy);
    modport slave  (input req, wen, addr, wdata, wstrb, output rdata, ack, busy);
`else
    modport master (output req, wen, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, wen, addr, wdata, output rdata, ack, busy);
`endif
endinterface

// File: rtl/unaligned_mem_port.sv
// Big-endian 32-bit port over four byte-wide banks; any byte alignment completes in one bank cycle.
// Define UNALIGNED_MEM_BYTE_MASK_EN to add per-byte write strobes (wstrb[3] gates byte addr).
module unaligned_mem_port #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    unaligned_mem_if.slave     bus
);
    localparam int ROWS = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [7:0]        rbyte_q [4];
    logic [7:0]        rbyte_d [4];

    // Bank storage is deliberately left out of reset so contents survive it.
    logic [7:0]        bank_mem [4][ROWS] = '{default: '0};

    logic [ADDR_W-1:0] byte_addr  [4];
    logic [ADDR_W-3:0] bank_row   [4];
    logic [7:0]        bank_wdata [4];
    logic              bank_we    [4];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = (state_q != IDLE) || bus.req;
        rbyte_d = rbyte_q;

        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_q + ADDR_W'(k);
        end

        // Bank j holds word byte k where k = (j - addr mod 4) mod 4.
        for (int j = 0; j < 4; j++) begin
            logic [1:0] kb;
            int         kk;
            kb            = 2'(j) - addr_q[1:0];
            kk            = int'(kb);
            bank_row[j]   = byte_addr[kk][ADDR_W-1:2];
            bank_wdata[j] = wdata_q[8*(3-kk) +: 8];
            bank_we[j]    = (state_q == ACCESS) && wen_q && strb_q[3-kk];
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wen_d   = bus.wen;
                    wdata_d = bus.wdata;
`ifdef UNALIGNED_MEM_BYTE_MASK_EN
                    strb_d  = bus.wstrb;
`else
                    strb_d  = 4'hF;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!wen_q) begin
                    for (int k = 0; k < 4; k++) begin
                        rbyte_d[k] = bank_mem[byte_addr[k][1:0]][byte_addr[k][ADDR_W-1:2]];
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                ack_d = 1'b1;
                if (!wen_q) begin
                    rdata_d = {rbyte_q[0], rbyte_q[1], rbyte_q[2], rbyte_q[3]};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                rbyte_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rbyte_q <= rbyte_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (bank_we[j]) begin
                bank_mem[j][bank_row[j]] <= bank_wdata[j];
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
endmodule

// File: doc/unaligned_mem_port.md
UNALIGNED_MEM_PORT -- requirements
Module: unaligned_mem_port

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width; each of the 4 banks holds 2^(ADDR_W-2) bytes.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have port req, input, 1, access request; the initiator holds it high until ack.
REQ-005 The block SHALL have port wen, input, 1, 1 = write, 0 = read; sampled with req.
REQ-006 The block SHALL have port addr, input, ADDR_W, byte address of the first (most significant) byte of the word.
REQ-007 The block SHALL have port wdata, input, 32, write word; sampled with req.
REQ-008 The block SHALL have port rdata, output, 32, read word; valid while ack is high.
REQ-009 The block SHALL have port ack, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have port busy, output, 1, high from request capture until the cycle after ack.

Function
REQ-011 Storage SHALL be 4 byte-wide banks; byte address b SHALL reside in bank b mod 4, row b div 4.
REQ-012 Words SHALL be big-endian: bits [31:24] at addr, [23:16] at addr+1, [15:8] at addr+2, [7:0] at addr+3.
REQ-013 Byte addresses SHALL wrap modulo 2^ADDR_W, e.g. addr=0xFE touches 0xFE, 0xFF, 0x00, 0x01.
REQ-014 Any alignment SHALL complete in one bank-access cycle; per-bank row = (addr + k) div 4 for the byte k that maps to that bank, with data rotated by addr mod 4.
REQ-015 The FSM SHALL have states IDLE, ACCESS, RESP.
REQ-016 IDLE: when req=1, the block SHALL capture addr, wen, wdata, set busy, and go to ACCESS.
REQ-017 ACCESS: the block SHALL perform all four bank writes (wen=1) or reads (wen=0) on the same edge, then go to RESP.
REQ-018 RESP: the block SHALL drive ack=1 for exactly one cycle, with rdata = the assembled read word (reads) or the unchanged previous rdata (writes), then go to IDLE.
REQ-019 Latency SHALL be fixed: req is sampled at edge N, and ack is high in the cycle after edge N+2.
REQ-020 In IDLE after ack, req still high SHALL start a new access; back-to-back throughput SHALL be one access per 3 cycles.
REQ-021 Changes to addr, wen or wdata after capture SHALL have no effect on the access in flight.
REQ-022 A read that overlaps bytes written by the immediately preceding write SHALL return the new data.
REQ-023 rdata SHALL hold its value between acks.

Reset
REQ-024 While rst=1: state = IDLE, ack = 0, busy = 0, rdata = 0x00000000, taking effect immediately without a clock edge.
REQ-025 Reset asserted before the ACCESS edge SHALL abort the access with no bank modified; a write is never partial.
REQ-026 Bank contents SHALL NOT be cleared by reset; simulation initial contents SHALL be all zero.

Configuration
REQ-027 With macro UNALIGNED_MEM_BYTE_MASK_EN defined, the block SHALL add input wstrb[3:0], sampled with req; wstrb[3] gates byte addr, wstrb[0] gates byte addr+3, and unmasked bytes keep their old value.
REQ-028 With the macro undefined, wstrb SHALL be absent and every write SHALL update all four bytes.

Verification
REQ-029 Aligned round trip: write 0x12345678 to addr 0x00, then read 0x00 -> rdata 0x12345678; read 0x01 -> 0x345678xx, where xx is byte 0x04 (0x00 after init).
REQ-030 Unaligned write: write 0xAABBCCDD to addr 0x05 -> byte reads at 0x05..0x08 return AA, BB, CC, DD; read 0x04 -> 0x00AABBCC.
REQ-031 Wrap: write 0xCAFEF00D to addr 0xFE -> read 0x00 returns 0xF00D0000 and read 0xFE returns 0xCAFEF00D.
REQ-032 Timing/handshake: req held high continuously -> ack pulses every 3 cycles, each 1 cycle wide; busy deasserts only in cycles with no capture pending.
REQ-033 Reset mid-op: assert rst during ACCESS of a write of 0xFFFFFFFF to 0x10 -> ack never pulses, busy=0, rdata=0; a later read of 0x10 returns the prior contents (0x00000000).
REQ-034 With UNALIGNED_MEM_BYTE_MASK_EN: write 0x11223344 with wstrb=4'b1010 to addr 0x20 over 0x00000000 -> read 0x20 returns 0x11003300.
